// File: rtl/btn_updown_counter_if.sv
// Board-side signal bundle for btn_updown_counter: raw buttons in, LEDs and event strobes out.
interface btn_updown_counter_if;
    logic BTN_UP;
    logic BTN_DN;
    logic LED0;
    logic LED1;
    logic LED2;
    logic UP_PULSE;
    logic DN_PULSE;

    modport master (
        output BTN_UP, BTN_DN,
        input  LED0, LED1, LED2, UP_PULSE, DN_PULSE
    );

    modport slave (
        input  BTN_UP, BTN_DN,
        output LED0, LED1, LED2, UP_PULSE, DN_PULSE
    );
endinterface

// File: rtl/btn_updown_counter.sv
// Debounced two-button up/down 3-bit counter driving active-low LEDs.
// Define AUTO_REPEAT_EN to add hold-to-repeat events on each button.
module btn_updown_counter #(
    parameter int TICK_DIV     = 12000,
    parameter int STABLE_TICKS = 10,
    parameter int REP_DELAY    = 500,
    parameter int REP_PERIOD   = 250
) (
    input  logic                   CLK12M,
    input  logic                   RST_N,
    btn_updown_counter_if.slave    bus
);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DC_W  = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(STABLE_TICKS - 1);

    localparam logic [1:0] S_RELEASED    = 2'd0;
    localparam logic [1:0] S_PRESS_CHK   = 2'd1;
    localparam logic [1:0] S_PRESSED     = 2'd2;
    localparam logic [1:0] S_RELEASE_CHK = 2'd3;

    if (TICK_DIV < 1 || STABLE_TICKS < 1 || REP_DELAY < 1 || REP_PERIOD < 1) begin : g_param_check
        $error("btn_updown_counter: all parameters must be at least 1");
    end

    // Index 0 is the up button, index 1 the down button throughout.
    logic [1:0]            r_s1, r_s2;
    logic [1:0]            w_p;
    logic [DIV_W-1:0]      r_div;
    logic                  w_tick;
    logic [1:0][1:0]       r_state, w_state_nx;
    logic [1:0][DC_W-1:0]  r_dcnt, w_dcnt_nx;
    logic [1:0]            w_evt;
    logic [1:0]            r_pulse;
    logic [2:0]            r_cnt;

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    logic [1:0][REP_W-1:0] r_rep, w_rep_nx;
    logic [1:0]            r_rpt, w_rpt_nx;
    logic [REP_W-1:0]      w_rep_inc;
    logic [REP_W-1:0]      w_rep_tgt;
`endif

    assign w_p    = ~r_s2;
    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge CLK12M) begin
        if (!RST_N) begin
            r_s1  <= 2'b11;
            r_s2  <= 2'b11;
            r_div <= '0;
        end else begin
            r_s1  <= {bus.BTN_DN, bus.BTN_UP};
            r_s2  <= r_s1;
            r_div <= w_tick ? '0 : r_div + 1'b1;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_dcnt_nx  = r_dcnt;
        w_evt      = '0;
`ifdef AUTO_REPEAT_EN
        w_rep_nx   = r_rep;
        w_rpt_nx   = r_rpt;
        w_rep_inc  = '0;
        w_rep_tgt  = '0;
`endif
        if (w_tick) begin
            for (int b = 0; b < 2; b++) begin
                case (r_state[b])
                    S_RELEASED: begin
                        if (w_p[b]) begin
                            w_state_nx[b] = S_PRESS_CHK;
                            w_dcnt_nx[b]  = DC_W'(1);
                        end
                    end
                    S_PRESS_CHK: begin
                        if (!w_p[b]) begin
                            w_state_nx[b] = S_RELEASED;
                            w_dcnt_nx[b]  = '0;
                        end else if (r_dcnt[b] >= DC_LAST) begin
                            w_state_nx[b] = S_PRESSED;
                            w_dcnt_nx[b]  = '0;
                            w_evt[b]      = 1'b1;
`ifdef AUTO_REPEAT_EN
                            w_rep_nx[b]   = '0;
                            w_rpt_nx[b]   = 1'b0;
`endif
                        end else begin
                            w_dcnt_nx[b]  = r_dcnt[b] + 1'b1;
                        end
                    end
                    S_PRESSED: begin
                        if (!w_p[b]) begin
                            w_state_nx[b] = S_RELEASE_CHK;
                            w_dcnt_nx[b]  = DC_W'(1);
                        end
`ifdef AUTO_REPEAT_EN
                        // First repeat after REP_DELAY held ticks, then every REP_PERIOD.
                        else begin
                            w_rep_inc = r_rep[b] + 1'b1;
                            w_rep_tgt = r_rpt[b] ? REP_W'(REP_PERIOD) : REP_W'(REP_DELAY);
                            if (w_rep_inc == w_rep_tgt) begin
                                w_evt[b]    = 1'b1;
                                w_rep_nx[b] = '0;
                                w_rpt_nx[b] = 1'b1;
                            end else begin
                                w_rep_nx[b] = w_rep_inc;
                            end
                        end
`endif
                    end
                    default: begin
                        if (w_p[b]) begin
                            w_state_nx[b] = S_PRESSED;
                            w_dcnt_nx[b]  = '0;
`ifdef AUTO_REPEAT_EN
                            w_rep_nx[b]   = '0;
                            w_rpt_nx[b]   = 1'b0;
`endif
                        end else if (r_dcnt[b] >= DC_LAST) begin
                            w_state_nx[b] = S_RELEASED;
                            w_dcnt_nx[b]  = '0;
                        end else begin
                            w_dcnt_nx[b]  = r_dcnt[b] + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK12M) begin
        if (!RST_N) begin
            r_state <= {S_RELEASED, S_RELEASED};
            r_dcnt  <= '0;
            r_pulse <= '0;
        end else begin
            r_state <= w_state_nx;
            r_dcnt  <= w_dcnt_nx;
            r_pulse <= w_evt;
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge CLK12M) begin
        if (!RST_N) begin
            r_rep <= '0;
            r_rpt <= '0;
        end else begin
            r_rep <= w_rep_nx;
            r_rpt <= w_rpt_nx;
        end
    end
`endif

    // Count follows the strobes; simultaneous up and down cancel.
    always_ff @(posedge CLK12M) begin
        if (!RST_N) begin
            r_cnt <= '0;
        end else begin
            case (r_pulse)
                2'b01:   r_cnt <= r_cnt + 3'd1;
                2'b10:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign bus.UP_PULSE = r_pulse[0];
    assign bus.DN_PULSE = r_pulse[1];
    assign bus.LED0     = ~r_cnt[0];
    assign bus.LED1     = ~r_cnt[1];
    assign bus.LED2     = ~r_cnt[2];
endmodule

// File: tb/tb_btn_updown_counter.sv
// Randomised and directed bench for btn_updown_counter against a level/streak behavioural model.
module tb_btn_updown_counter;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam int RD = 5;
    localparam int RP = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    btn_updown_counter_if ifc();

    btn_updown_counter #(
        .TICK_DIV(TD), .STABLE_TICKS(ST), .REP_DELAY(RD), .REP_PERIOD(RP)
    ) dut (
        .CLK12M(clk),
        .RST_N (rst_n),
        .bus   (ifc)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    logic [2:0] led;
    assign led = {ifc.LED2, ifc.LED1, ifc.LED0};

    // Behavioural model: each button has an accepted level and a streak of
    // disagreeing tick samples; ST in a row flips the level.
    bit m_started = 0;
    int m_raw1[2], m_raw2[2];
    int m_ncyc;
    int m_lvl[2], m_dis[2], m_held[2];
    int m_up, m_dn, m_cnt;

    always @(posedge clk) begin
        int p[2];
        int ev[2];
        bit tick;
        if (!rst_n) begin
            m_started = 1;
            for (int b = 0; b < 2; b++) begin
                m_raw1[b] = 1; m_raw2[b] = 1;
                m_lvl[b] = 0; m_dis[b] = 0; m_held[b] = 0;
            end
            m_ncyc = 0; m_up = 0; m_dn = 0; m_cnt = 0;
        end else if (m_started) begin
            m_cnt = (m_cnt + 8 + m_up - m_dn) % 8;
            for (int b = 0; b < 2; b++) p[b] = (m_raw2[b] == 0) ? 1 : 0;
            m_raw2 = m_raw1;
            m_raw1[0] = ifc.BTN_UP ? 1 : 0;
            m_raw1[1] = ifc.BTN_DN ? 1 : 0;
            tick = ((m_ncyc % TD) == TD - 1);
            m_ncyc++;
            for (int b = 0; b < 2; b++) begin
                ev[b] = 0;
                if (tick) begin
                    if (p[b] == m_lvl[b]) begin
                        if (m_lvl[b] == 1 && m_dis[b] == 0) begin
                            m_held[b]++;
`ifdef AUTO_REPEAT_EN
                            if (m_held[b] == RD || (m_held[b] > RD && (m_held[b] - RD) % RP == 0))
                                ev[b] = 1;
`endif
                        end
                        m_dis[b] = 0;
                    end else begin
                        m_dis[b]++;
                        m_held[b] = 0;
                        if (m_dis[b] >= ST) begin
                            m_lvl[b] = p[b];
                            m_dis[b] = 0;
                            if (p[b] == 1) ev[b] = 1;
                        end
                    end
                end
            end
            m_up = ev[0];
            m_dn = ev[1];
        end
    end

    int n_up = 0, n_dn = 0, n_both = 0;

    always @(negedge clk) begin
        if (m_started) begin
            check("up_pulse", int'(ifc.UP_PULSE), m_up);
            check("dn_pulse", int'(ifc.DN_PULSE), m_dn);
            check("leds", int'(led), (~m_cnt) & 7);
            if (ifc.UP_PULSE === 1'b1) n_up++;
            if (ifc.DN_PULSE === 1'b1) n_dn++;
            if (ifc.UP_PULSE === 1'b1 && ifc.DN_PULSE === 1'b1) n_both++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
    endtask

    task automatic press_up(input int hold, input int gap);
        ifc.BTN_UP = 1'b0; cyc(hold);
        ifc.BTN_UP = 1'b1; cyc(gap);
    endtask

    initial begin
        int s_up, s_dn, s_both, first;
        int t[4];
        int k;
        ifc.BTN_UP = 1'b1;
        ifc.BTN_DN = 1'b1;

        rst_n = 1'b0;
        cyc(3);
        check("reset_leds", int'(led), 7);
        check("reset_up", int'(ifc.UP_PULSE), 0);
        check("reset_dn", int'(ifc.DN_PULSE), 0);
        rst_n = 1'b1;
        cyc(5);

        s_up = n_up;
        press_up(24, 30);
        check("clean_press_pulses", n_up - s_up, 1);
        check("clean_press_led0", int'(ifc.LED0), 0);
        check("clean_press_leds", int'(led), 6);

        s_up = n_up;
        for (int i = 0; i < 10; i++) begin
            ifc.BTN_UP = (i % 2 == 0) ? 1'b0 : 1'b1;
            cyc(3);
        end
        press_up(20, 30);
        check("bounce_pulses", n_up - s_up, 1);

        s_up = n_up;
        press_up(8, 30);
        check("glitch_pulses", n_up - s_up, 0);
        check("glitch_leds", int'(led), 5);

        do_reset();
        for (int i = 0; i < 8; i++) press_up(24, 20);
        check("wrap_up_leds", int'(led), 7);
        s_dn = n_dn;
        ifc.BTN_DN = 1'b0; cyc(24);
        ifc.BTN_DN = 1'b1; cyc(30);
        check("wrap_dn_pulses", n_dn - s_dn, 1);
        check("wrap_dn_leds", int'(led), 0);

        s_up = n_up; s_dn = n_dn; s_both = n_both;
        ifc.BTN_UP = 1'b0; ifc.BTN_DN = 1'b0; cyc(24);
        ifc.BTN_UP = 1'b1; ifc.BTN_DN = 1'b1; cyc(30);
        check("simul_both", n_both - s_both, 1);
        check("simul_up", n_up - s_up, 1);
        check("simul_dn", n_dn - s_dn, 1);
        check("simul_leds", int'(led), 0);

        s_up = n_up;
        ifc.BTN_UP = 1'b0; cyc(8);
        check("midreset_pre_pulses", n_up - s_up, 0);
        rst_n = 1'b0; cyc(3);
        check("midreset_leds", int'(led), 7);
        rst_n = 1'b1;
        first = 0;
        s_up = n_up;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ifc.UP_PULSE === 1'b1 && first == 0) first = i;
        end
        ifc.BTN_UP = 1'b1; cyc(30);
        check("midreset_latency", first, 12);
        check("midreset_pulses", n_up - s_up, 1);

`ifdef AUTO_REPEAT_EN
        do_reset();
        ifc.BTN_UP = 1'b0;
        k = 0;
        for (int i = 1; i <= 80 && k < 4; i++) begin
            @(negedge clk);
            if (ifc.UP_PULSE === 1'b1) begin t[k] = i; k++; end
        end
        ifc.BTN_UP = 1'b1; cyc(30);
        check("rep_count", k, 4);
        check("rep_first", t[0], 12);
        check("rep_delay", t[1] - t[0], RD * TD);
        check("rep_period1", t[2] - t[1], RP * TD);
        check("rep_period2", t[3] - t[2], RP * TD);
`else
        k = 0;
        t[0] = 0;
`endif

        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0) ifc.BTN_UP = ~ifc.BTN_UP;
            if ($urandom_range(0, 11) == 0) ifc.BTN_DN = ~ifc.BTN_DN;
            if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b1;
        cyc(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
